// File: rtl/audio_sample_conditioner.sv
// Stereo soft-mute and underrun conditioner that drives audio_sample_word into the HDMI packet picker.
// Define AUDIO_SAMPLE_CONDITIONER_UNDERRUN_COUNT_EN to build the underrun_count statistic counter.
module audio_sample_conditioner #(
  parameter int AUDIO_BIT_WIDTH = 16,
  parameter int RAMP_SHIFT      = 8,
  parameter int UNDERRUN_LIMIT  = 4
) (
  input  logic                              clk_audio,
  input  logic                              reset,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic signed [AUDIO_BIT_WIDTH-1:0] in_left,
  input  logic signed [AUDIO_BIT_WIDTH-1:0] in_right,
  input  logic                              mute_req,
  output logic signed [AUDIO_BIT_WIDTH-1:0] audio_sample_word [2],
  output logic        [RAMP_SHIFT:0]        gain,
  output logic        [1:0]                 state,
  output logic                              underrun,
  output logic        [15:0]                underrun_count
);

  localparam int GW = RAMP_SHIFT + 1;
  localparam int PW = AUDIO_BIT_WIDTH + RAMP_SHIFT + 2;
  localparam logic [GW-1:0] GMAX     = {1'b1, {RAMP_SHIFT{1'b0}}};
  localparam logic [GW-1:0] GAIN_ONE = GW'(1);
  localparam logic [7:0]    LIMIT    = 8'(UNDERRUN_LIMIT);

  typedef enum logic [1:0] {
    MUTED     = 2'b00,
    RAMP_UP   = 2'b01,
    PLAY      = 2'b10,
    RAMP_DOWN = 2'b11
  } state_t;

  state_t                              r_state;
  logic        [GW-1:0]                r_gain;
  logic signed [AUDIO_BIT_WIDTH-1:0]   r_holdL;
  logic signed [AUDIO_BIT_WIDTH-1:0]   r_holdR;
  logic signed [AUDIO_BIT_WIDTH-1:0]   r_wordL;
  logic signed [AUDIO_BIT_WIDTH-1:0]   r_wordR;
  logic        [7:0]                   r_missCount;
  logic                                r_underrun;

  logic                                w_handshake;
  logic        [7:0]                   w_missNext;
  logic signed [AUDIO_BIT_WIDTH-1:0]   w_curL;
  logic signed [AUDIO_BIT_WIDTH-1:0]   w_curR;
  logic signed [GW:0]                  w_gainS;
  logic signed [PW-1:0]                w_prodL;
  logic signed [PW-1:0]                w_prodR;
  logic signed [AUDIO_BIT_WIDTH-1:0]   w_scaledL;
  logic signed [AUDIO_BIT_WIDTH-1:0]   w_scaledR;

  assign in_ready    = ~reset;
  assign w_handshake = in_valid & in_ready;

  // On a missed sample the last accepted one is repeated rather than dropping to zero.
  assign w_curL = w_handshake ? in_left  : r_holdL;
  assign w_curR = w_handshake ? in_right : r_holdR;

  assign w_missNext = w_handshake ? 8'd0 :
                      (r_missCount == 8'hFF) ? r_missCount : r_missCount + 8'd1;

  // Gain is zero-extended to stay positive; the wide product cannot overflow even at -full-scale * GMAX.
  assign w_gainS   = $signed({1'b0, r_gain});
  assign w_prodL   = PW'(w_curL) * PW'(w_gainS);
  assign w_prodR   = PW'(w_curR) * PW'(w_gainS);
  assign w_scaledL = AUDIO_BIT_WIDTH'(w_prodL >>> RAMP_SHIFT);
  assign w_scaledR = AUDIO_BIT_WIDTH'(w_prodR >>> RAMP_SHIFT);

  always_ff @(posedge clk_audio) begin
    if (reset) begin
      r_holdL     <= '0;
      r_holdR     <= '0;
      r_wordL     <= '0;
      r_wordR     <= '0;
      r_missCount <= '0;
      r_underrun  <= 1'b0;
    end else begin
      if (w_handshake) begin
        r_holdL <= in_left;
        r_holdR <= in_right;
      end
      r_missCount <= w_missNext;
      r_underrun  <= ~w_handshake;
      r_wordL     <= w_scaledL;
      r_wordR     <= w_scaledR;
    end
  end

  // Ramps only move one step per sample; an abort from RAMP_UP continues downward from the current gain.
  always_ff @(posedge clk_audio) begin
    if (reset) begin
      r_state <= MUTED;
      r_gain  <= '0;
    end else begin
      case (r_state)
        MUTED: begin
          r_gain <= '0;
          if (!mute_req && in_valid) begin
            r_state <= RAMP_UP;
          end
        end
        RAMP_UP: begin
          if (mute_req) begin
            if (r_gain <= GAIN_ONE) begin
              r_gain  <= '0;
              r_state <= MUTED;
            end else begin
              r_gain  <= r_gain - GAIN_ONE;
              r_state <= RAMP_DOWN;
            end
          end else if (r_gain >= GMAX - GAIN_ONE) begin
            r_gain  <= GMAX;
            r_state <= PLAY;
          end else begin
            r_gain <= r_gain + GAIN_ONE;
          end
        end
        PLAY: begin
          r_gain <= GMAX;
          if (mute_req || (w_missNext >= LIMIT)) begin
            r_state <= RAMP_DOWN;
          end
        end
        RAMP_DOWN: begin
          if (r_gain <= GAIN_ONE) begin
            r_gain  <= '0;
            r_state <= MUTED;
          end else begin
            r_gain <= r_gain - GAIN_ONE;
          end
        end
        default: begin
          r_gain  <= '0;
          r_state <= MUTED;
        end
      endcase
    end
  end

`ifdef AUDIO_SAMPLE_CONDITIONER_UNDERRUN_COUNT_EN
  logic [15:0] r_underrunCount;

  // Only misses while audio is audible are counted; the count sticks at all-ones.
  always_ff @(posedge clk_audio) begin
    if (reset) begin
      r_underrunCount <= '0;
    end else if ((r_state != MUTED) && !w_handshake && (r_underrunCount != 16'hFFFF)) begin
      r_underrunCount <= r_underrunCount + 16'd1;
    end
  end

  assign underrun_count = r_underrunCount;
`else
  assign underrun_count = 16'd0;
`endif

  assign audio_sample_word[0] = r_wordL;
  assign audio_sample_word[1] = r_wordR;
  assign gain                 = r_gain;
  assign state                = r_state;
  assign underrun             = r_underrun;

endmodule

// File: tb/tb_audio_sample_conditioner.sv
// Directed bench for audio_sample_conditioner with RAMP_SHIFT=2 (GMAX=4), 16-bit samples, underrun limit 4.
// Expected values are hand-derived from the gain ramp and floor-scaling rules.
module tb_audio_sample_conditioner;

  logic               clk_audio;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] in_left;
  logic signed [15:0] in_right;
  logic               mute_req;
  logic signed [15:0] audio_sample_word [2];
  logic        [2:0]  gain;
  logic        [1:0]  state;
  logic               underrun;
  logic        [15:0] underrun_count;

  int assertCount = 0;
  int failCount   = 0;

  audio_sample_conditioner #(
    .AUDIO_BIT_WIDTH(16),
    .RAMP_SHIFT(2),
    .UNDERRUN_LIMIT(4)
  ) dut (
    .clk_audio(clk_audio),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_left(in_left),
    .in_right(in_right),
    .mute_req(mute_req),
    .audio_sample_word(audio_sample_word),
    .gain(gain),
    .state(state),
    .underrun(underrun),
    .underrun_count(underrun_count)
  );

  initial clk_audio = 1'b0;
  always #5 clk_audio = ~clk_audio;

  // Drive one sample period, then settle just after the edge so registered outputs are stable.
  task automatic applyStimulus(input logic valid, input logic signed [15:0] l,
                               input logic signed [15:0] r, input logic mute);
    in_valid = valid;
    in_left  = l;
    in_right = r;
    mute_req = mute;
    @(posedge clk_audio);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)",
             tag, $signed(observed), observed, $signed(expected), expected);
    end
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_left  = '0;
    in_right = '0;
    mute_req = 1'b0;
    #1;
    checkOutput("in_ready in reset", 32'(in_ready), 0);
    applyStimulus(1'b0, 16'sh0000, 16'sh0000, 1'b0);
    applyStimulus(1'b0, 16'sh0000, 16'sh0000, 1'b0);
    checkOutput("reset state", 32'(state), 0);
    checkOutput("reset gain", 32'(gain), 0);
    checkOutput("reset L", 32'(audio_sample_word[0]), 0);
    checkOutput("reset R", 32'(audio_sample_word[1]), 0);
    checkOutput("reset underrun", 32'(underrun), 0);
    checkOutput("reset underrun_count", 32'(underrun_count), 0);
    reset = 1'b0;
    #1;
    checkOutput("in_ready out of reset", 32'(in_ready), 1);

    $display("[TB] ramp up from mute");
    applyStimulus(1'b1, 16'sh1000, 16'shF000, 1'b0);
    checkOutput("up0 state", 32'(state), 1);
    checkOutput("up0 gain", 32'(gain), 0);
    checkOutput("up0 L", 32'(audio_sample_word[0]), 0);
    applyStimulus(1'b1, 16'sh1000, 16'shF000, 1'b0);
    checkOutput("up1 gain", 32'(gain), 1);
    checkOutput("up1 L", 32'(audio_sample_word[0]), 0);
    applyStimulus(1'b1, 16'sh1000, 16'shF000, 1'b0);
    checkOutput("up2 gain", 32'(gain), 2);
    checkOutput("up2 L", 32'(audio_sample_word[0]), 32'h0400);
    checkOutput("up2 R", 32'(audio_sample_word[1]), -1024);
    applyStimulus(1'b1, 16'sh1000, 16'shF000, 1'b0);
    checkOutput("up3 gain", 32'(gain), 3);
    checkOutput("up3 L", 32'(audio_sample_word[0]), 32'h0800);
    applyStimulus(1'b1, 16'sh1000, 16'shF000, 1'b0);
    checkOutput("up4 state", 32'(state), 2);
    checkOutput("up4 gain", 32'(gain), 4);
    checkOutput("up4 L", 32'(audio_sample_word[0]), 32'h0C00);
    applyStimulus(1'b1, 16'sh1000, 16'shF000, 1'b0);
    checkOutput("play state", 32'(state), 2);
    checkOutput("play L", 32'(audio_sample_word[0]), 32'h1000);
    checkOutput("play R", 32'(audio_sample_word[1]), -4096);
    checkOutput("play underrun", 32'(underrun), 0);

    $display("[TB] mute pulse in play");
    applyStimulus(1'b1, 16'sh1000, 16'shF000, 1'b1);
    checkOutput("mute state", 32'(state), 3);
    checkOutput("mute gain", 32'(gain), 4);
    checkOutput("mute L", 32'(audio_sample_word[0]), 32'h1000);
    applyStimulus(1'b0, 16'sh0000, 16'sh0000, 1'b0);
    checkOutput("down1 gain", 32'(gain), 3);
    checkOutput("down1 held L", 32'(audio_sample_word[0]), 32'h1000);
    checkOutput("down1 underrun", 32'(underrun), 1);
    applyStimulus(1'b0, 16'sh0000, 16'sh0000, 1'b0);
    checkOutput("down2 gain", 32'(gain), 2);
    checkOutput("down2 L", 32'(audio_sample_word[0]), 32'h0C00);
    applyStimulus(1'b0, 16'sh0000, 16'sh0000, 1'b0);
    checkOutput("down3 gain", 32'(gain), 1);
    checkOutput("down3 L", 32'(audio_sample_word[0]), 32'h0800);
    applyStimulus(1'b0, 16'sh0000, 16'sh0000, 1'b0);
    checkOutput("down4 gain", 32'(gain), 0);
    checkOutput("down4 state", 32'(state), 0);
    checkOutput("down4 L", 32'(audio_sample_word[0]), 32'h0400);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 16'sh0000, 16'sh0000, 1'b0);
    end
    checkOutput("idle state", 32'(state), 0);
    checkOutput("idle L", 32'(audio_sample_word[0]), 0);
    checkOutput("idle R", 32'(audio_sample_word[1]), 0);

    $display("[TB] underrun in play");
    reset = 1'b1;
    applyStimulus(1'b0, 16'sh0000, 16'sh0000, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 16'sh0123, 16'sh0200, 1'b0);
    end
    checkOutput("urun ramp state", 32'(state), 2);
    applyStimulus(1'b1, 16'sh0123, 16'sh0200, 1'b0);
    checkOutput("urun last L", 32'(audio_sample_word[0]), 32'h0123);
    checkOutput("urun last underrun", 32'(underrun), 0);
    applyStimulus(1'b0, 16'sh0000, 16'sh0000, 1'b0);
    checkOutput("miss1 L", 32'(audio_sample_word[0]), 32'h0123);
    checkOutput("miss1 underrun", 32'(underrun), 1);
    applyStimulus(1'b0, 16'sh0000, 16'sh0000, 1'b0);
    applyStimulus(1'b0, 16'sh0000, 16'sh0000, 1'b0);
    checkOutput("miss3 state", 32'(state), 2);
    checkOutput("miss3 L", 32'(audio_sample_word[0]), 32'h0123);
    applyStimulus(1'b0, 16'sh0000, 16'sh0000, 1'b0);
    checkOutput("miss4 state", 32'(state), 3);
    checkOutput("miss4 gain", 32'(gain), 4);
    applyStimulus(1'b0, 16'sh0000, 16'sh0000, 1'b0);
    checkOutput("miss5 gain", 32'(gain), 3);
    checkOutput("miss5 L", 32'(audio_sample_word[0]), 32'h0123);
    applyStimulus(1'b0, 16'sh0000, 16'sh0000, 1'b0);
    checkOutput("miss6 gain", 32'(gain), 2);
    checkOutput("miss6 L", 32'(audio_sample_word[0]), 32'h00DA);
    checkOutput("miss6 R", 32'(audio_sample_word[1]), 32'h0180);
`ifdef AUDIO_SAMPLE_CONDITIONER_UNDERRUN_COUNT_EN
    checkOutput("miss6 underrun_count", 32'(underrun_count), 6);
`else
    checkOutput("miss6 underrun_count", 32'(underrun_count), 0);
`endif
    applyStimulus(1'b0, 16'sh0000, 16'sh0000, 1'b0);
    applyStimulus(1'b0, 16'sh0000, 16'sh0000, 1'b0);
    checkOutput("urun muted state", 32'(state), 0);

    $display("[TB] abort ramp up");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 16'sh1000, 16'sh1000, 1'b0);
    end
    checkOutput("abort pre gain", 32'(gain), 2);
    checkOutput("abort pre state", 32'(state), 1);
    applyStimulus(1'b1, 16'sh1000, 16'sh1000, 1'b1);
    checkOutput("abort state", 32'(state), 3);
    checkOutput("abort gain", 32'(gain), 1);
    applyStimulus(1'b0, 16'sh0000, 16'sh0000, 1'b1);
    checkOutput("abort end state", 32'(state), 0);
    checkOutput("abort end gain", 32'(gain), 0);

    $display("[TB] negative full scale and floor");
    applyStimulus(1'b1, 16'sh8000, 16'sh8000, 1'b0);
    applyStimulus(1'b1, 16'sh8000, 16'sh8000, 1'b0);
    applyStimulus(1'b1, 16'sh8000, 16'sh8000, 1'b0);
    checkOutput("neg gain1 L", 32'(audio_sample_word[0]), -8192);
    applyStimulus(1'b1, 16'sh8000, 16'sh8000, 1'b0);
    checkOutput("neg gain2 L", 32'(audio_sample_word[0]), -16384);
    applyStimulus(1'b1, 16'shFFFF, 16'sh0001, 1'b0);
    checkOutput("floor L", 32'(audio_sample_word[0]), -1);
    checkOutput("floor R", 32'(audio_sample_word[1]), 0);
    checkOutput("floor state", 32'(state), 2);
    applyStimulus(1'b1, 16'sh8000, 16'sh7FFF, 1'b0);
    checkOutput("fullscale L", 32'(audio_sample_word[0]), -32768);
    checkOutput("fullscale R", 32'(audio_sample_word[1]), 32767);

    $display("[TB] reset mid ramp down");
    applyStimulus(1'b1, 16'sh8000, 16'sh7FFF, 1'b1);
    applyStimulus(1'b1, 16'sh8000, 16'sh7FFF, 1'b0);
    checkOutput("pre reset state", 32'(state), 3);
    checkOutput("pre reset gain", 32'(gain), 3);
    reset = 1'b1;
    #1;
    checkOutput("in_ready mid reset", 32'(in_ready), 0);
    applyStimulus(1'b1, 16'sh8000, 16'sh7FFF, 1'b0);
    checkOutput("midreset state", 32'(state), 0);
    checkOutput("midreset gain", 32'(gain), 0);
    checkOutput("midreset L", 32'(audio_sample_word[0]), 0);
    checkOutput("midreset R", 32'(audio_sample_word[1]), 0);
    checkOutput("midreset underrun_count", 32'(underrun_count), 0);
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/audio_sample_conditioner.md
Name: audio_sample_conditioner

Overview:
- Sits in the clk_audio domain directly upstream of the HDMI packet picker.
- Produces the stereo audio_sample_word that the picker captures on every clk_audio edge; one clk_audio cycle is one audio sample period.
- Accepts a valid/ready stereo sample stream from the audio source (FIFO or tone generator) and handles stream underrun.
- Applies a linear soft-mute gain ramp so that mute, unmute and underrun never produce hard amplitude steps on the HDMI link.

Parameters:
- AUDIO_BIT_WIDTH, 16: signed sample width per channel; legal range 16..24.
- RAMP_SHIFT, 8: ramp length is 2^RAMP_SHIFT samples; gain full-scale GMAX = 2^RAMP_SHIFT; legal range 1..12.
- UNDERRUN_LIMIT, 4: consecutive underrun samples in PLAY that force a ramp-down; legal range 1..255.

Ports:
- clk_audio  in  1  sample-rate clock.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  input sample available.
- in_ready  out  1  block consumes input this cycle.
- in_left  in  AUDIO_BIT_WIDTH  signed left sample.
- in_right  in  AUDIO_BIT_WIDTH  signed right sample.
- mute_req  in  1  level; 1 requests a ramp to silence.
- audio_sample_word  out  2 x AUDIO_BIT_WIDTH  unpacked array; [0] = left, [1] = right; feeds the packet picker.
- gain  out  RAMP_SHIFT+1  current gain, 0..GMAX.
- state  out  2  00 MUTED, 01 RAMP_UP, 10 PLAY, 11 RAMP_DOWN.
- underrun  out  1  registered; 1 when the previous cycle had no valid input.
- underrun_count  out  16  see Optional Feature.

Behaviour:
- Reset is synchronous, active-high, clock clk_audio. Reset values:
  - state = MUTED, gain = 0, audio_sample_word = {0,0}, underrun = 0, underrun_count = 0.
  - Held sample = 0; consecutive-underrun counter = 0.
  - in_ready = 0 during reset and 1 in every non-reset cycle. A handshake occurs when in_valid & in_ready.
- Sample select, per cycle:
  - Handshake: current sample = {in_left, in_right}; the held sample is updated to it.
  - No handshake: current sample = held sample (repeat last), underrun <= 1, and the consecutive-underrun counter increments, saturating at 255.
  - Any handshake clears the consecutive-underrun counter.
- Gain arithmetic:
  - out = (sample * gain) >>> RAMP_SHIFT.
  - Signed multiply, product width AUDIO_BIT_WIDTH+RAMP_SHIFT+2, arithmetic shift (truncates toward negative infinity).
  - At gain = GMAX, out equals the input bit-exactly. At gain = 0, out = 0.
  - The gain used is the registered gain value before this cycle's update.
- Latency: an input accepted in cycle N appears on audio_sample_word at the edge ending cycle N (one register stage).
- State machine (transitions are evaluated on registered state):
  - MUTED: gain = 0. Goes to RAMP_UP when !mute_req & in_valid.
  - RAMP_UP: gain += 1 per cycle.
    - Goes to PLAY in the cycle gain reaches GMAX.
    - mute_req = 1 goes to RAMP_DOWN immediately, starting from the current gain with no jump.
    - Underruns in RAMP_UP do not abort the ramp.
  - PLAY: gain = GMAX. Goes to RAMP_DOWN when mute_req = 1 or the consecutive-underrun counter reaches UNDERRUN_LIMIT. Simultaneous causes give the same transition.
  - RAMP_DOWN: gain -= 1 per cycle; goes to MUTED when gain reaches 0. Deasserting mute_req mid-ramp does not reverse the ramp; the block returns through MUTED.
  - From MUTED, the next RAMP_UP can start the cycle after gain = 0 is reached.
- Boundaries:
  - gain never leaves 0..GMAX.
  - Holding in_valid = 0 indefinitely in MUTED keeps the output at 0.
  - Reset asserted mid-ramp forces MUTED / gain 0 on the next edge.
  - A held sample of the most-negative value multiplied by GMAX must not overflow.

Optional Feature:
- Macro AUDIO_SAMPLE_CONDITIONER_UNDERRUN_COUNT_EN.
- Defined: underrun_count is a 16-bit saturating counter of no-handshake cycles outside MUTED. It holds at 16'hFFFF and clears only on reset.
- Undefined: underrun_count is tied to 16'd0 and no counter logic is synthesised. All other behaviour is identical.

Test Plan (RAMP_SHIFT=2, so GMAX=4; AUDIO_BIT_WIDTH=16; UNDERRUN_LIMIT=4):
- Reset, then in_valid=1 with constant L=0x1000, R=-0x1000, mute_req=0 -> gain steps 0,1,2,3,4. Left output steps 0x0000, 0x0400, 0x0800, 0x0C00, 0x1000. state goes MUTED, RAMP_UP x4, PLAY.
- In PLAY, pulse mute_req for 1 cycle -> RAMP_DOWN, gain steps 4,3,2,1,0, then MUTED. Output stays 0 while mute_req=0 and in_valid=0.
- In PLAY, hold in_valid=0 for 6 cycles after L=0x0123 -> output repeats 0x0123 for 3 cycles, underrun=1. On the 4th consecutive miss, RAMP_DOWN begins. With the macro defined, underrun_count=6.
- In RAMP_UP at gain=2, assert mute_req -> next gain is 1 (no jump to 4); MUTED is reached after 2 more cycles.
- Input L=-32768 in PLAY -> output -32768 exactly. At gain=1, output -8192. At gain=3 with L=-1, output -1 (floor).
- Assert reset at gain=3 in RAMP_DOWN -> next edge gives state=00, gain=0, output {0,0}, underrun_count=0.
